uart_rx_fifo: RTL and testbench

Receive front end for the secondary UART (uart2_rxd). It deserialises 8N1 frames (optionally 8E1) from the asynchronous pin, buffers the received bytes in a first-word-fall-through FIFO, and presents them to the CPU-side UART peripheral through a valid/pop interface. It also latches sticky error flags for that peripheral to read and clear.

---
 rtl/uart_pkg.sv | 18 +
 rtl/byte_fifo.sv | 51 +++++
 rtl/uart_rx_fifo.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart2 receive front end.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned bit_clks(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO; simultaneous push/pop allowed, even when full.
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart2 receiver: synchroniser, 8N1 deserialiser, FWFT byte FIFO, sticky errors.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          uart_rxd,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          parity_err,
  input  logic                          err_clr
);

  localparam int unsigned BIT_CLKS  = bit_clks(CLK_HZ, BAUD);
  localparam int unsigned HALF_CLKS = BIT_CLKS / 2;
  localparam int unsigned CNT_W     = $clog2(BIT_CLKS + 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CLKS - 1);

  logic             rx_meta;
  logic             rxs;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic             ovr_set;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rxs     <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`endif

  // Counter counts down to zero; each state samples rxs on the zero cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      push      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      push <= 1'b0;
      if (err_clr) begin
        frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
      case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= HALF_LOAD;
            state <= START;
          end
        end
        START: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (!rxs) begin
            cnt     <= BIT_LOAD;
            bit_idx <= '0;
            state   <= DATA;
          end else state <= IDLE;
        end
        DATA: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            shift   <= {rxs, shift[7:1]};
            cnt     <= BIT_LOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            par_bad <= (rxs != ^shift);
            if (rxs != ^shift) parity_err <= 1'b1;
            cnt   <= BIT_LOAD;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (!rxs) begin
            frame_err <= 1'b1;
            state     <= BREAK;
          end else begin
`ifdef UART_RX_PARITY_EN
            push <= !par_bad;
`else
            push <= 1'b1;
`endif
            state <= IDLE;
          end
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .push     (push),
    .push_data(shift),
    .pop      (rd_en),
    .head     (rd_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign rd_valid = !fifo_empty;
  assign ovr_set  = push && fifo_full && !(rd_en && !fifo_empty);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)      overrun <= 1'b0;
    else if (ovr_set) overrun <= 1'b1;
    else if (err_clr) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;

  localparam int BITC  = 10;
  localparam int DEPTH = 16;

  logic       sys_clk  = 1'b0;
  logic       sys_rst  = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       rd_en    = 1'b0;
  logic       err_clr  = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] fifo_count;
  logic       overrun;
  logic       frame_err;
  logic       parity_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic exp_ovr = 1'b0;

  uart_rx_fifo #(
    .CLK_HZ    (1_000_000),
    .BAUD      (100_000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .uart_rxd  (uart_rxd),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .fifo_count(fifo_count),
    .overrun   (overrun),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .err_clr   (err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic model_push(input logic [7:0] d);
    if (q.size() < DEPTH) q.push_back(d);
    else exp_ovr = 1'b1;
  endtask

  // Drives one frame; a low stop bit leaves the line held low.
  task automatic send_frame(input logic [7:0] d, input bit par_bad = 1'b0, input bit stop = 1'b1);
    uart_rxd = 1'b0;
    idle(BITC);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      idle(BITC);
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = (^d) ^ par_bad;
    idle(BITC);
`endif
    uart_rxd = stop;
    idle(BITC);
    if (stop) begin
      idle(BITC);
`ifdef UART_RX_PARITY_EN
      if (!par_bad) model_push(d);
`else
      model_push(d);
`endif
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, "_valid"}, 32'(rd_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk({tag, "_data"}, 32'(rd_data), 32'(q[0]));
    chk({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
  endtask

  task automatic pop_one(input string tag);
    check_state(tag);
    rd_en = 1'b1;
    @(negedge sys_clk);
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
    exp_ovr = 1'b0;
  endtask

  initial begin
    idle(3);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_data", 32'(rd_data), 32'h00);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    sys_rst = 1'b0;
    idle(5);

    // Single frame
    send_frame(8'hA5);
    chk("a5_data", 32'(rd_data), 32'hA5);
    chk("a5_count", 32'(fifo_count), 32'd1);
    pop_one("a5_pop");
    chk("a5_after_valid", 32'(rd_valid), 32'd0);
    chk("a5_after_count", 32'(fifo_count), 32'd0);

    // Pop while empty is ignored
    pop_one("empty_pop");
    check_state("empty_after");

    // Overfill
    for (int i = 0; i <= 16; i++) send_frame(8'(i));
    chk("full_count", 32'(fifo_count), 32'd16);
    chk("full_ovr", 32'(overrun), 32'd1);
    for (int i = 0; i < 16; i++) pop_one("drain");
    check_state("drained");
    clear_errs();
    chk("ovr_clr", 32'(overrun), 32'd0);

    // Framing error followed by a held-low line
    send_frame(8'h55, 1'b0, 1'b0);
    chk("ferr_set", 32'(frame_err), 32'd1);
    check_state("ferr_nopush");
    clear_errs();
    idle(50);
    uart_rxd = 1'b1;
    idle(150);
    chk("ferr_once", 32'(frame_err), 32'd0);
    check_state("ferr_break");
    send_frame(8'h3C);
    pop_one("after_break");

    // Short glitch
    uart_rxd = 1'b0;
    idle(3);
    uart_rxd = 1'b1;
    idle(30);
    check_state("glitch");
    chk("glitch_ferr", 32'(frame_err), 32'd0);
    chk("glitch_perr", 32'(parity_err), 32'd0);
    send_frame(8'h5A);
    pop_one("after_glitch");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b1);
    chk("par_bad", 32'(parity_err), 32'd1);
    check_state("par_nopush");
    clear_errs();
    chk("par_clr", 32'(parity_err), 32'd0);
    send_frame(8'h01, 1'b0);
    chk("par_good", 32'(parity_err), 32'd0);
    pop_one("par_pop");
`endif

    // Reset mid-frame with bytes buffered
    send_frame(8'h11);
    send_frame(8'h22);
    check_state("pre_rst");
    uart_rxd = 1'b0;
    idle(BITC);
    uart_rxd = 1'b1;
    idle(BITC / 2);
    sys_rst = 1'b1;
    q.delete();
    exp_ovr = 1'b0;
    idle(2);
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_data", 32'(rd_data), 32'h00);
    sys_rst = 1'b0;
    idle(30);
    check_state("post_rst");
    chk("post_rst_data", 32'(rd_data), 32'h00);
    chk("post_rst_ferr", 32'(frame_err), 32'd0);
    send_frame(8'h7E);
    chk("rst_7e_count", 32'(fifo_count), 32'd1);
    chk("rst_7e_data", 32'(rd_data), 32'h7E);
    pop_one("rst_7e_pop");

    // Randomized traffic with random drains
    for (int n = 0; n < 40; n++) begin
      send_frame(8'($urandom_range(0, 255)));
      check_state("rnd");
      if (q.size() >= 12 || $urandom_range(0, 2) == 0) begin
        int k = $urandom_range(1, q.size());
        for (int j = 0; j < k; j++) pop_one("rnd_pop");
      end
    end
    while (q.size() != 0) pop_one("rnd_drain");
    check_state("final");
    chk("final_ferr", 32'(frame_err), 32'd0);
    chk("final_perr", 32'(parity_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
